pipeline_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage MIPS pipeline.
- Drives the enable and clear inputs of the F/D/E/M/W pipeline registers, including the IF/ID register (en, clr) and the PC enable.
- Generates bypass selects for the EX and ID (branch-compare) operands.
- Tracks the multi-cycle mult/div unit busy window and counts stall cycles.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_if.sv | 34 +++
 rtl/pipeline_ctrl_mdu_busy_tracker.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 96 +++++++++
 tb/tb_pipeline_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, types and the EX bypass select helper for the pipeline controller.
package pipeline_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {IDLE, BUSY} mdu_state_t;

  // MEM result is younger than WB, so it takes precedence; r0 is hardwired zero.
  function automatic logic [1:0] ex_fwd_sel(input logic [4:0] src,
                                            input logic       we_m,
                                            input logic [4:0] wr_m,
                                            input logic       we_w,
                                            input logic [4:0] wr_w);
    if (we_m && (wr_m != 5'd0) && (wr_m == src)) return FWD_MEM;
    if (we_w && (wr_w != 5'd0) && (wr_w == src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-to-controller bundle: hazard inputs from each stage and the enables/bypass selects back.
interface pipeline_ctrl_if;

  logic [4:0]  RsD, RtD, RsE, RtE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemtoRegE, MemtoRegM;
  logic        BranchD, PCSrcD, MdUseD, MdStartE, MdDivE;
  logic        DmemReqM, DmemReadyM;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD;
  logic        EnF, EnD, EnE, EnM, EnW;
  logic        ClrD, ClrE;
  logic        MdBusy;
  logic [31:0] StallCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdUseD, MdStartE, MdDivE, DmemReqM, DmemReadyM,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, MdBusy, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdUseD, MdStartE, MdDivE, DmemReqM, DmemReadyM,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, MdBusy, StallCount
  );

endinterface

// File: rtl/pipeline_ctrl_mdu_busy_tracker.sv
// Tracks the mult/div busy window: MdBusy is high for exactly MULT_CYCLES or DIV_CYCLES
// cycles after an accepted start; a start while busy is ignored.
module mdu_busy_tracker
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MdStartE,
  input  logic MdDivE,
  input  logic accept,
  output logic MdBusy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_t       state;
  logic [CNT_W-1:0] md_cnt;

  // Counting continues through memory stalls: the unit runs independently of the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      md_cnt <= '0;
      MdBusy <= 1'b0;
    end else if (state == IDLE) begin
      if (MdStartE && accept) begin
        md_cnt <= MdDivE ? DIV_LOAD : MULT_LOAD;
        state  <= BUSY;
        MdBusy <= 1'b1;
      end
    end else begin
      if (md_cnt == '0) begin
        state  <= IDLE;
        MdBusy <= 1'b0;
      end else begin
        md_cnt <= md_cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline: combinational enables,
// clears and bypass selects, plus the MDU busy tracker and a saturating stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  logic md_busy;
  logic lwstall, branchstall, mdstall, memstall, dstall;
  logic e_hit, m_hit;
  logic en_f, en_d, en_e, en_m, en_w, clr_d, clr_e;
  logic [31:0] stall_cnt;

  assign bus.ForwardAE = ex_fwd_sel(bus.RsE, bus.RegWriteM, bus.WriteRegM, bus.RegWriteW, bus.WriteRegW);
  assign bus.ForwardBE = ex_fwd_sel(bus.RtE, bus.RegWriteM, bus.WriteRegM, bus.RegWriteW, bus.WriteRegW);
  assign bus.ForwardAD = bus.RegWriteM && (bus.WriteRegM != 5'd0) && (bus.WriteRegM == bus.RsD);
  assign bus.ForwardBD = bus.RegWriteM && (bus.WriteRegM != 5'd0) && (bus.WriteRegM == bus.RtD);

  assign lwstall = bus.MemtoRegE && (bus.RtE != 5'd0) &&
                   ((bus.RtE == bus.RsD) || (bus.RtE == bus.RtD));

  // Branch compare in ID cannot see an ALU result still in EX, nor load data still in MEM.
  assign e_hit = bus.RegWriteE && (bus.WriteRegE != 5'd0) &&
                 ((bus.WriteRegE == bus.RsD) || (bus.WriteRegE == bus.RtD));
  assign m_hit = bus.MemtoRegM && (bus.WriteRegM != 5'd0) &&
                 ((bus.WriteRegM == bus.RsD) || (bus.WriteRegM == bus.RtD));
  assign branchstall = bus.BranchD && (e_hit || m_hit);

  assign mdstall  = bus.MdUseD && (md_busy || bus.MdStartE);
  assign memstall = bus.DmemReqM && !bus.DmemReadyM;
  assign dstall   = lwstall || branchstall || mdstall;

  always_comb begin
    en_f  = 1'b1;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    en_w  = 1'b1;
    clr_d = 1'b0;
    clr_e = 1'b0;
    if (memstall) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
    end else if (dstall) begin
      // Redirect is dropped here; the branch re-resolves once the hazard clears.
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end else if (bus.PCSrcD) begin
      clr_d = 1'b1;
    end
  end

  assign bus.EnF    = en_f;
  assign bus.EnD    = en_d;
  assign bus.EnE    = en_e;
  assign bus.EnM    = en_m;
  assign bus.EnW    = en_w;
  assign bus.ClrD   = clr_d;
  assign bus.ClrE   = clr_e;
  assign bus.MdBusy = md_busy;

  mdu_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .MdStartE (bus.MdStartE),
    .MdDivE   (bus.MdDivE),
    .accept   (!memstall),
    .MdBusy   (md_busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!en_f && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.StallCount = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  logic clk = 1'b0;
  logic rst_n;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: remaining busy cycles of the MDU and the stall tally.
  int          m_busy_left = 0;
  logic [31:0] m_stall     = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] ref_ex(input logic [4:0] src);
    logic [4:0] prod_reg [2];
    logic       prod_we  [2];
    logic [1:0] prod_sel [2];
    prod_reg[0] = bus.WriteRegM; prod_we[0] = bus.RegWriteM; prod_sel[0] = 2'b10;
    prod_reg[1] = bus.WriteRegW; prod_we[1] = bus.RegWriteW; prod_sel[1] = 2'b01;
    for (int i = 0; i < 2; i++)
      if (src != 0 && prod_we[i] && prod_reg[i] == src) return prod_sel[i];
    return 2'b00;
  endfunction

  function automatic logic reads(input logic [4:0] r);
    return (r != 0) && (r == bus.RsD || r == bus.RtD);
  endfunction

  task automatic drive_zero();
    bus.RsD = 0; bus.RtD = 0; bus.RsE = 0; bus.RtE = 0;
    bus.WriteRegE = 0; bus.WriteRegM = 0; bus.WriteRegW = 0;
    bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.MemtoRegE = 0; bus.MemtoRegM = 0;
    bus.BranchD = 0; bus.PCSrcD = 0; bus.MdUseD = 0;
    bus.MdStartE = 0; bus.MdDivE = 0; bus.DmemReqM = 0; bus.DmemReadyM = 0;
  endtask

  // Compare every output against the model, clock once, then advance the model.
  task automatic step();
    logic mem_s, d_s, busy, xf, xd, xe, xcd, xce;
    #1;
    busy  = (m_busy_left > 0);
    mem_s = bus.DmemReqM && !bus.DmemReadyM;
    d_s   = (bus.MemtoRegE && reads(bus.RtE)) ||
            (bus.BranchD && ((bus.RegWriteE && reads(bus.WriteRegE)) ||
                             (bus.MemtoRegM && reads(bus.WriteRegM)))) ||
            (bus.MdUseD && (busy || bus.MdStartE));
    xf = !(mem_s || d_s);
    xd = xf;
    xe = !mem_s;
    xce = !mem_s && d_s;
    xcd = !mem_s && !d_s && bus.PCSrcD;
    chk("ForwardAE", 32'(bus.ForwardAE), 32'(ref_ex(bus.RsE)));
    chk("ForwardBE", 32'(bus.ForwardBE), 32'(ref_ex(bus.RtE)));
    chk("ForwardAD", 32'(bus.ForwardAD), 32'(ref_ex(bus.RsD) == 2'b10));
    chk("ForwardBD", 32'(bus.ForwardBD), 32'(ref_ex(bus.RtD) == 2'b10));
    chk("EnF", 32'(bus.EnF), 32'(xf));
    chk("EnD", 32'(bus.EnD), 32'(xd));
    chk("EnE", 32'(bus.EnE), 32'(xe));
    chk("EnM", 32'(bus.EnM), 32'(xe));
    chk("EnW", 32'(bus.EnW), 32'(xe));
    chk("ClrD", 32'(bus.ClrD), 32'(xcd));
    chk("ClrE", 32'(bus.ClrE), 32'(xce));
    chk("MdBusy", 32'(bus.MdBusy), 32'(busy));
    chk("StallCount", bus.StallCount, m_stall);
    @(posedge clk);
    if (!rst_n) begin
      m_busy_left = 0;
      m_stall     = 32'd0;
    end else begin
      if (!xf && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (m_busy_left > 0) begin
        if (bus.MdStartE) $display("note: MdStartE presented while MDU busy at %0t, ignored", $time);
        m_busy_left--;
      end else if (bus.MdStartE && !mem_s) begin
        m_busy_left = bus.MdDivE ? DIV_N : MULT_N;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    rst_n = 1'b0;
    drive_zero();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    #1;
    chk("reset_MdBusy", 32'(bus.MdBusy), 32'd0);
    chk("reset_StallCount", bus.StallCount, 32'd0);

    // Back-to-back ALU ops: MEM beats WB, r0 never forwarded.
    bus.RegWriteM = 1; bus.WriteRegM = 5; bus.RsE = 5; bus.RegWriteW = 1; bus.WriteRegW = 5;
    #1 chk("t1_fwd_mem_wins", 32'(bus.ForwardAE), 32'd2);
    step();
    bus.WriteRegM = 0; bus.RsE = 0;
    #1 chk("t1_fwd_r0", 32'(bus.ForwardAE), 32'd0);
    step();

    // Load-use stall.
    drive_zero();
    bus.MemtoRegE = 1; bus.RtE = 8; bus.RsD = 8;
    #1;
    chk("t2_EnF", 32'(bus.EnF), 32'd0);
    chk("t2_EnD", 32'(bus.EnD), 32'd0);
    chk("t2_ClrE", 32'(bus.ClrE), 32'd1);
    step();
    bus.MemtoRegE = 0;
    #1;
    chk("t2_StallCount", bus.StallCount, 32'd1);
    chk("t2_EnD_release", 32'(bus.EnD), 32'd1);
    step();

    // Taken branch, then the same with a branch hazard.
    drive_zero();
    bus.PCSrcD = 1;
    #1;
    chk("t3_ClrD", 32'(bus.ClrD), 32'd1);
    chk("t3_EnD", 32'(bus.EnD), 32'd1);
    step();
    bus.BranchD = 1; bus.RegWriteE = 1; bus.WriteRegE = 3; bus.RsD = 3;
    #1;
    chk("t3_hz_ClrD", 32'(bus.ClrD), 32'd0);
    chk("t3_hz_EnD", 32'(bus.EnD), 32'd0);
    chk("t3_hz_ClrE", 32'(bus.ClrE), 32'd1);
    step();

    // Divide then multiply with a dependent MdUseD held high.
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? DIV_N : MULT_N;
      drive_zero();
      bus.MdStartE = 1; bus.MdDivE = (k == 0); bus.MdUseD = 1;
      step();
      bus.MdStartE = 0;
      for (int i = 1; i <= n; i++) begin
        #1;
        chk("t4_busy", 32'(bus.MdBusy), 32'd1);
        chk("t4_EnD_held", 32'(bus.EnD), 32'd0);
        step();
      end
      #1;
      chk("t4_idle", 32'(bus.MdBusy), 32'd0);
      chk("t4_EnD_release", 32'(bus.EnD), 32'd1);
      step();
    end

    // A start while busy must not reload the counter.
    drive_zero();
    bus.MdStartE = 1;
    step();
    bus.MdStartE = 0;
    step();
    bus.MdStartE = 1;
    step();
    bus.MdStartE = 0;
    for (int i = 0; i < 4; i++) step();

    // Memory wait dominates a load-use stall.
    drive_zero();
    bus.DmemReqM = 1; bus.MemtoRegE = 1; bus.RtE = 8; bus.RsD = 8;
    base = m_stall;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_EnW", 32'(bus.EnW), 32'd0);
      chk("t5_EnF", 32'(bus.EnF), 32'd0);
      chk("t5_ClrE", 32'(bus.ClrE), 32'd0);
      step();
    end
    drive_zero();
    #1 chk("t5_StallCount", bus.StallCount, base + 32'd3);
    step();

    // Reset in the middle of a divide.
    bus.MdStartE = 1; bus.MdDivE = 1;
    step();
    bus.MdStartE = 0;
    for (int i = 0; i < 11; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_MdBusy", 32'(bus.MdBusy), 32'd0);
    chk("t6_StallCount", bus.StallCount, 32'd0);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      bus.RsD = 5'($urandom_range(0, 3)); bus.RtD = 5'($urandom_range(0, 3));
      bus.RsE = 5'($urandom_range(0, 3)); bus.RtE = 5'($urandom_range(0, 3));
      bus.WriteRegE = 5'($urandom_range(0, 3));
      bus.WriteRegM = 5'($urandom_range(0, 3));
      bus.WriteRegW = 5'($urandom_range(0, 3));
      bus.RegWriteE = 1'($urandom_range(0, 1));
      bus.RegWriteM = 1'($urandom_range(0, 1));
      bus.RegWriteW = 1'($urandom_range(0, 1));
      bus.MemtoRegE = ($urandom_range(0, 3) == 0);
      bus.MemtoRegM = ($urandom_range(0, 3) == 0);
      bus.BranchD   = ($urandom_range(0, 3) == 0);
      bus.PCSrcD    = ($urandom_range(0, 2) == 0);
      bus.MdUseD    = ($urandom_range(0, 3) == 0);
      bus.MdStartE  = (m_busy_left == 0) && ($urandom_range(0, 7) == 0);
      bus.MdDivE    = ($urandom_range(0, 3) == 0);
      bus.DmemReqM  = ($urandom_range(0, 3) == 0);
      bus.DmemReadyM = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
